// File: rtl/mcycle_unit_if.sv
// Request/result bundle between the instruction decoder and the multiply/divide unit.
interface mcycle_unit_if #(
    parameter int W = 32
);
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy
    );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per clock,
// W steps per operation, sign fix-up applied on the final step.
module mcycle_unit #(
    parameter int W = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    mcycle_unit_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic {IDLE, COMPUTING} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mag_a_q, mag_a_d;
    logic [W-1:0]   mag_b_q, mag_b_d;
    logic           sign_a_q, sign_a_d;
    logic           sign_b_q, sign_b_d;
    logic           is_div_q, is_div_d;
    logic [W-1:0]   result1_q, result1_d;
    logic [W-1:0]   result2_q, result2_d;

    logic [CW-1:0]  bit_idx;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_ge;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] step_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic           op_signed;

    // Both algorithms walk the operand bits MSB first, so the accumulator can start cleared.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        is_div_d  = is_div_q;
        result1_d = result1_q;
        result2_d = result2_q;

        bit_idx   = CW'(W - 1) - count_q;
        mul_next  = {acc_q[2*W-2:0], 1'b0}
                  + (mag_b_q[bit_idx] ? {{W{1'b0}}, mag_a_q} : {(2*W){1'b0}});
        div_shift = {acc_q[2*W-1:W], mag_a_q[bit_idx]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        div_ge    = ~div_diff[W];
        div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
        step_next = is_div_q ? div_next : mul_next;
        prod_fix  = (sign_a_q ^ sign_b_q) ? -step_next : step_next;
        quo       = step_next[W-1:0];
        rem       = step_next[2*W-1:W];
        op_signed = ~bus.MCycleOp[0];

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d  = COMPUTING;
                    count_d  = '0;
                    acc_d    = '0;
                    is_div_d = bus.MCycleOp[1];
                    sign_a_d = op_signed & bus.Operand1[W-1];
                    sign_b_d = op_signed & bus.Operand2[W-1];
                    mag_a_d  = sign_a_d ? -bus.Operand1 : bus.Operand1;
                    mag_b_d  = sign_b_d ? -bus.Operand2 : bus.Operand2;
                end
            end
            COMPUTING: begin
                acc_d   = step_next;
                count_d = count_q + 1'b1;
                if (count_q == CW'(W - 1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    if (!is_div_q) begin
                        result1_d = prod_fix[W-1:0];
                        result2_d = prod_fix[2*W-1:W];
                    end else if (mag_b_q == '0) begin
                        // Rebuild the original dividend from its magnitude and sign.
                        result1_d = '1;
                        result2_d = sign_a_q ? -mag_a_q : mag_a_q;
                    end else begin
                        result1_d = (sign_a_q ^ sign_b_q) ? -quo : quo;
                        result2_d = sign_a_q ? -rem : rem;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            is_div_q  <= 1'b0;
            result1_q <= '0;
            result2_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            is_div_q  <= is_div_d;
            result1_q <= result1_d;
            result2_q <= result2_d;
        end
    end

    // Busy is combinational from Start so the requesting instruction stalls in its own cycle.
    assign bus.Busy    = ~RESET & (((state_q == IDLE) & bus.Start) | (state_q == COMPUTING));
    assign bus.Result1 = result1_q;
    assign bus.Result2 = result2_q;
endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard testbench for mcycle_unit: expected results are queued at issue time and
// popped when the unit drops Busy.
module tb_mcycle_unit;
    logic CLK;
    logic RESET;
    int   tests_run;
    int   tests_failed;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    exp_t sb[$];

    mcycle_unit_if #(.W(32)) bus ();

    mcycle_unit #(.W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model built on the native operators, magnitudes first then sign fix-up.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r1, output logic [31:0] r2);
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        logic [63:0] p;
        na = ~op[0] & a[31];
        nb = ~op[0] & b[31];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        if (!op[1]) begin
            p = {32'b0, ma} * {32'b0, mb};
            if (na ^ nb) p = -p;
            r1 = p[31:0];
            r2 = p[63:32];
        end else if (b == 32'd0) begin
            r1 = 32'hFFFF_FFFF;
            r2 = a;
        end else begin
            q = ma / mb;
            r = ma % mb;
            r1 = (na ^ nb) ? -q : q;
            r2 = na ? -r : r;
        end
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        bus.Start    = 1'b1;
    endtask

    task automatic push_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.r1 = e1;
        e.r2 = e2;
        sb.push_back(e);
        issue(op, a, b);
    endtask

    // Counts Busy cycles starting in the issue cycle; flags any result change while busy.
    task automatic wait_done(input bit scramble, output int n, output bit changed);
        logic [31:0] h1, h2;
        n       = 0;
        changed = 1'b0;
        #1;
        h1 = bus.Result1;
        h2 = bus.Result2;
        while (bus.Busy && n < 200) begin
            n++;
            if (bus.Result1 !== h1 || bus.Result2 !== h2) changed = 1'b1;
            @(negedge CLK);
            if (scramble && n < 20) begin
                bus.Start    = 1'($urandom_range(0, 1));
                bus.Operand1 = $urandom;
                bus.Operand2 = $urandom;
                bus.MCycleOp = 2'($urandom_range(0, 3));
            end else begin
                bus.Start = 1'b0;
            end
            #1;
        end
    endtask

    task automatic test_reset;
        RESET        = 1'b1;
        bus.Start    = 1'b1;
        bus.MCycleOp = 2'b01;
        bus.Operand1 = 32'd5;
        bus.Operand2 = 32'd6;
        repeat (2) @(negedge CLK);
        #1;
        tests_run++;
        if (bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.Busy);
        end
        tests_run++;
        if (bus.Result1 !== 32'd0 || bus.Result2 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_results: got %h/%h expected 0/0", bus.Result2, bus.Result1);
        end
        RESET     = 1'b0;
        bus.Start = 1'b0;
        #1;
        tests_run++;
        if (bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle_busy: got %b expected 0", bus.Busy);
        end
    endtask

    task automatic test_signed_mul;
        int   n;
        bit   ch;
        exp_t e;
        push_issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
        wait_done(1'b0, n, ch);
        e = sb.pop_front();
        tests_run++;
        if (n !== 33) begin
            tests_failed++;
            $display("[TB] FAIL smul_latency: got %0d busy cycles expected 33", n);
        end
        tests_run++;
        if (bus.Result1 !== e.r1 || bus.Result2 !== e.r2) begin
            tests_failed++;
            $display("[TB] FAIL smul_result: got %h/%h expected %h/%h", bus.Result2, bus.Result1, e.r2, e.r1);
        end
    endtask

    task automatic test_unsigned_mul;
        logic [1:0]  ops[2] = '{2'b01, 2'b00};
        logic [31:0] hi[2]  = '{32'hFFFF_FFFE, 32'h0000_0000};
        int   n;
        bit   ch;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            push_issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, hi[i]);
            wait_done(1'b0, n, ch);
            e = sb.pop_front();
            tests_run++;
            if (n !== 33 || bus.Result1 !== e.r1 || bus.Result2 !== e.r2) begin
                tests_failed++;
                $display("[TB] FAIL mul_ff_op%0d: got %0d cyc %h/%h expected 33 cyc %h/%h",
                         ops[i], n, bus.Result2, bus.Result1, e.r2, e.r1);
            end
        end
    endtask

    task automatic test_divide;
        logic [1:0]  ops[3] = '{2'b10, 2'b11, 2'b10};
        logic [31:0] a[3]   = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] b[3]   = '{32'd2, 32'd7, 32'hFFFF_FFFF};
        logic [31:0] q[3]   = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000};
        logic [31:0] r[3]   = '{32'hFFFF_FFFF, 32'd2, 32'd0};
        int   n;
        bit   ch;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            push_issue(ops[i], a[i], b[i], q[i], r[i]);
            wait_done(1'b0, n, ch);
            e = sb.pop_front();
            tests_run++;
            if (n !== 33 || bus.Result1 !== e.r1 || bus.Result2 !== e.r2) begin
                tests_failed++;
                $display("[TB] FAIL div_%0d: got %0d cyc Q=%h R=%h expected 33 cyc Q=%h R=%h",
                         i, n, bus.Result1, bus.Result2, e.r1, e.r2);
            end
        end
    endtask

    task automatic test_div_zero;
        int   n;
        bit   ch;
        exp_t e;
        push_issue(2'b11, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234);
        wait_done(1'b0, n, ch);
        e = sb.pop_front();
        tests_run++;
        if (n !== 33) begin
            tests_failed++;
            $display("[TB] FAIL divzero_latency: got %0d expected 33", n);
        end
        tests_run++;
        if (bus.Result1 !== e.r1 || bus.Result2 !== e.r2) begin
            tests_failed++;
            $display("[TB] FAIL divzero_result: got %h/%h expected %h/%h", bus.Result1, bus.Result2, e.r1, e.r2);
        end
    endtask

    task automatic test_ignore_start;
        int   n;
        bit   ch;
        exp_t e;
        push_issue(2'b11, 32'd1000, 32'd33, 32'd30, 32'd10);
        wait_done(1'b1, n, ch);
        e = sb.pop_front();
        tests_run++;
        if (n !== 33) begin
            tests_failed++;
            $display("[TB] FAIL ignore_latency: got %0d expected 33", n);
        end
        tests_run++;
        if (ch !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ignore_hold: got change=%b expected 0", ch);
        end
        tests_run++;
        if (bus.Result1 !== e.r1 || bus.Result2 !== e.r2) begin
            tests_failed++;
            $display("[TB] FAIL ignore_result: got %h/%h expected %h/%h", bus.Result1, bus.Result2, e.r1, e.r2);
        end
    endtask

    task automatic test_reset_mid;
        int   n;
        bit   ch;
        exp_t e;
        issue(2'b01, 32'h0000_1234, 32'h0000_5678);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            bus.Start = 1'b0;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        tests_run++;
        if (bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_busy: got %b expected 0", bus.Busy);
        end
        tests_run++;
        if (bus.Result1 !== 32'd0 || bus.Result2 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_results: got %h/%h expected 0/0", bus.Result2, bus.Result1);
        end
        push_issue(2'b00, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FD00, 32'hFFFF_FFFF);
        wait_done(1'b0, n, ch);
        e = sb.pop_front();
        tests_run++;
        if (n !== 33 || bus.Result1 !== e.r1 || bus.Result2 !== e.r2) begin
            tests_failed++;
            $display("[TB] FAIL after_abort: got %0d cyc %h/%h expected 33 cyc %h/%h",
                     n, bus.Result2, bus.Result1, e.r2, e.r1);
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a, b, e1, e2;
        int   n;
        bit   ch;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            model(op, a, b, e1, e2);
            push_issue(op, a, b, e1, e2);
            wait_done(1'b0, n, ch);
            e = sb.pop_front();
            tests_run++;
            if (n !== 33 || bus.Result1 !== e.r1 || bus.Result2 !== e.r2) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got %0d cyc %h/%h expected 33 cyc %h/%h",
                         i, op, a, b, n, bus.Result2, bus.Result1, e.r2, e.r1);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   busy_a;
        int   n;
        int   unstable;
        exp_t ea, eb;
        ea.r1 = 32'h0000_0000; ea.r2 = 32'h0000_0001;
        eb.r1 = 32'hFFFF_FFF2; eb.r2 = 32'hFFFF_FFFE;
        sb.push_back(ea);
        sb.push_back(eb);
        issue(2'b01, 32'h0001_0000, 32'h0001_0000);
        busy_a = 0;
        for (int k = 0; k < 33; k++) begin
            #1;
            if (bus.Busy) busy_a++;
            @(negedge CLK);
        end
        bus.MCycleOp = 2'b10;
        bus.Operand1 = 32'hFFFF_FF9C;
        bus.Operand2 = 32'd7;
        #1;
        ea = sb.pop_front();
        tests_run++;
        if (busy_a !== 33) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_busy: got %0d expected 33", busy_a);
        end
        tests_run++;
        if (bus.Result1 !== ea.r1 || bus.Result2 !== ea.r2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_result: got %h/%h expected %h/%h", bus.Result2, bus.Result1, ea.r2, ea.r1);
        end
        n = 0;
        unstable = 0;
        while (bus.Busy && n < 200) begin
            n++;
            if (bus.Result1 !== ea.r1 || bus.Result2 !== ea.r2) unstable++;
            @(negedge CLK);
            bus.Start = 1'b0;
            #1;
        end
        eb = sb.pop_front();
        tests_run++;
        if (n !== 33) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_busy: got %0d expected 33", n);
        end
        tests_run++;
        if (unstable !== 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold: got %0d changed cycles expected 0", unstable);
        end
        tests_run++;
        if (bus.Result1 !== eb.r1 || bus.Result2 !== eb.r2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_result: got Q=%h R=%h expected Q=%h R=%h",
                     bus.Result1, bus.Result2, eb.r1, eb.r2);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RESET        = 1'b1;
        bus.Start    = 1'b0;
        bus.MCycleOp = 2'b00;
        bus.Operand1 = 32'd0;
        bus.Operand2 = 32'd0;
        test_reset();
        test_signed_mul();
        test_unsigned_mul();
        test_divide();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
